rgb_de_rx: RTL and testbench
============================

RGB_DE_RX -- requirements
Module: rgb_de_rx

Interface
REQ-001 Parameter VBLANK_CYC, default 12'd2048: consecutive lcd_de-low clocks that mark vertical blanking. It exceeds the longest horizontal blank and is shorter than the shortest vertical blank of the supported panels.
REQ-002 lcd_pclk  input  1  pixel clock; the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 lcd_de  input  1  DE-mode data enable; hs/vs are not used.
REQ-005 lcd_rgb  input  16  RGB565 pixel, valid while lcd_de=1.
REQ-006 pix_valid  output  1  registered pixel strobe.
REQ-007 pix_data  output  16  registered pixel value.
REQ-008 pix_x  output  11  column of pix_data, 0-based.
REQ-009 pix_y  output  11  row of pix_data, 0-based.
REQ-010 sof  output  1  high with pixel (0,0).
REQ-011 eol  output  1  high with the last pixel of each line.
REQ-012 eof  output  1  high with the last pixel of the frame.
REQ-013 locked  output  1  format measured and being tracked.
REQ-014 fmt_err  output  1  one-cycle pulse on loss of lock.
REQ-015 h_disp_meas  output  11  measured active width; valid while locked.
REQ-016 v_disp_meas  output  11  measured active height; valid while locked.

Function
REQ-017 All outputs SHALL be registered, with one lcd_pclk of latency from the lcd_de/lcd_rgb sample.
REQ-018 Idle counter: 12 bits; cleared when lcd_de=1; incremented when lcd_de=0; saturates at VBLANK_CYC.
REQ-019 Vblank event: a single-cycle event on the clock where the idle counter reaches VBLANK_CYC.
REQ-020 Column counter x_cnt: counts samples with lcd_de=1 and clears on the lcd_de falling edge. The run length at that edge is the line width.
REQ-021 Row counter y_cnt: increments at each lcd_de falling edge, saturates at 2047, and clears on the vblank event.
REQ-022 State machine states are SEARCH, MEASURE and LOCKED.
REQ-023 SEARCH -> MEASURE on a vblank event.
REQ-024 MEASURE behaviour:
- the first line's width is captured;
- any later line of different width, or width 0 or >2047, returns the FSM to SEARCH without a fmt_err pulse;
- at the next vblank event with y_cnt>0, the FSM goes to LOCKED and loads h_disp_meas/v_disp_meas.
REQ-025 pix_valid SHALL assert only in LOCKED, for each sample with lcd_de=1 and x_cnt<h_disp_meas and y_cnt<v_disp_meas. pix_x=x_cnt and pix_y=y_cnt of that sample.
REQ-026 In LOCKED, each of the following is an error:
- overrun: lcd_de=1 with x_cnt==h_disp_meas; that sample is not emitted;
- short line: falling edge with width<h_disp_meas;
- extra line: rising edge with y_cnt==v_disp_meas;
- short frame: vblank event with y_cnt<v_disp_meas.
REQ-027 On any error, fmt_err SHALL pulse for one cycle and locked SHALL drop in the same registered cycle. The FSM enters SEARCH, and pix_valid stays 0 from that cycle on.
REQ-028 On a short-frame error, that same vblank event SHALL also count as the SEARCH->MEASURE trigger.
REQ-029 sof = pix_valid & pix_x==0 & pix_y==0.
REQ-030 eol = pix_valid & pix_x==h_disp_meas-1.
REQ-031 eof = eol & pix_y==v_disp_meas-1.
REQ-032 locked = (state==LOCKED). h_disp_meas/v_disp_meas hold their values after loss of lock until the next LOCKED entry.
REQ-033 Width arithmetic is 11-bit unsigned. A line width of exactly 2047 is legal, and a sample arriving while x_cnt==2047 is an overrun.

Reset
REQ-034 While rst=1, the module SHALL set:
- state=SEARCH;
- idle counter=0, x_cnt=0, y_cnt=0;
- pix_valid, sof, eol, eof, locked, fmt_err = 0;
- pix_data, pix_x, pix_y, h_disp_meas, v_disp_meas = 0.
REQ-035 Reset asserted mid-frame SHALL force those values at the next lcd_pclk edge. No fmt_err pulse is generated by reset.

Verification
REQ-036 Stimulus: 480x272 stream, 45-clock hblank, 14-line vblank (525-clock lines), starting mid-frame. Required: locked=1 after the second vblank event, h_disp_meas=480, v_disp_meas=272, and exactly 130560 pix_valid in the next frame.
REQ-037 Stimulus: 800x480 stream, 256-clock hblank. Required: per frame exactly one sof at (0,0), 480 eol at pix_x=799, and one eof at (799,479); pix_data equals lcd_rgb delayed by one clock.
REQ-038 Stimulus: locked at 480x272, row 100 shortened to 479 pixels. Required: one fmt_err pulse one clock after the lcd_de fall, locked=0, no further pix_valid, and relock two vblanks later.
REQ-039 Stimulus: locked at 480x272, one 481-pixel line. Required: the 481st sample is not emitted and fmt_err pulses one clock after it.
REQ-040 Stimulus: locked at 480x272, one frame of 273 lines. Required: fmt_err at the rising edge of row 272, with zero pix_valid for that row.
REQ-041 Stimulus: rst=1 for one clock mid-line while locked. Required: all outputs 0 at the next edge, no fmt_err, and relock two vblanks after release.

Source files
------------

// File: rtl/rgb_de_rx_if.sv
// Video bus between an RGB565 DE-mode panel source and the receiver.
// Ports: lcd_de/lcd_rgb from the source; pix_* and sof/eol/eof to the sink.
interface rgb_de_rx_if;
    logic        lcd_de;
    logic [15:0] lcd_rgb;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        sof;
    logic        eol;
    logic        eof;

    modport master (
        output lcd_de, lcd_rgb,
        input  pix_valid, pix_data, pix_x, pix_y, sof, eol, eof
    );

    modport slave (
        input  lcd_de, lcd_rgb,
        output pix_valid, pix_data, pix_x, pix_y, sof, eol, eof
    );
endinterface

// File: rtl/rgb_de_rx.sv
// DE-only RGB565 receiver: measures the active format, locks onto it,
// emits pixels with coordinates and frame markers, flags format loss.
// Ports: lcd_pclk, rst (sync, active high); vid (slave video bus);
//        locked, fmt_err, h_disp_meas, v_disp_meas status outputs.
module rgb_de_rx #(
    parameter logic [11:0] VBLANK_CYC = 12'd2048
) (
    input  logic        lcd_pclk,
    input  logic        rst,
    rgb_de_rx_if.slave  vid,
    output logic        locked,
    output logic        fmt_err,
    output logic [10:0] h_disp_meas,
    output logic [10:0] v_disp_meas
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state;
    state_t      state_n;
    logic [11:0] idle_cnt;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic        x_ovf;
    logic        de_d;
    logic [10:0] h_cap;
    logic        h_have;

    logic de;
    logic rise;
    logic fall;
    logic vb_evt;
    logic err_ovr;
    logic err_short;
    logic err_extra;
    logic err_frame;
    logic lock_err;
    logic pv;
    logic eol_n;
    logic cap_w;
    logic ld_meas;

    assign de   = vid.lcd_de;
    assign rise = de & ~de_d;
    assign fall = ~de & de_d;

    // Fires on the sample that takes the idle counter to VBLANK_CYC;
    // saturation keeps it from repeating within one blank.
    assign vb_evt = ~de & (idle_cnt == VBLANK_CYC - 12'd1);

    assign err_ovr   = de & (x_cnt == h_disp_meas);
    assign err_short = fall & (x_cnt < h_disp_meas);
    assign err_extra = rise & (y_cnt == v_disp_meas);
    assign err_frame = vb_evt & (y_cnt < v_disp_meas);
    assign lock_err  = (state == LOCKED) &
                       (err_ovr | err_short | err_extra | err_frame);

    assign pv = (state == LOCKED) & de & ~lock_err &
                (x_cnt < h_disp_meas) & (y_cnt < v_disp_meas);

    assign eol_n = pv & (x_cnt == h_disp_meas - 11'd1);

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        cap_w   = 1'b0;
        ld_meas = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vb_evt) state_n = MEASURE;
            end
            MEASURE: begin
                if (vb_evt) begin
                    if (y_cnt != 11'd0) begin
                        state_n = LOCKED;
                        ld_meas = 1'b1;
                    end
                end else if (fall) begin
                    if (x_ovf || x_cnt == 11'd0 ||
                        (h_have && x_cnt != h_cap)) begin
                        state_n = SEARCH;
                    end else if (!h_have) begin
                        cap_w = 1'b1;
                    end
                end
            end
            LOCKED: begin
                // A short frame's vblank doubles as the new search trigger.
                if (lock_err) state_n = vb_evt ? MEASURE : SEARCH;
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            idle_cnt      <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            x_ovf         <= 1'b0;
            de_d          <= 1'b0;
            h_cap         <= '0;
            h_have        <= 1'b0;
            h_disp_meas   <= '0;
            v_disp_meas   <= '0;
            locked        <= 1'b0;
            fmt_err       <= 1'b0;
            vid.pix_valid <= 1'b0;
            vid.pix_data  <= '0;
            vid.pix_x     <= '0;
            vid.pix_y     <= '0;
            vid.sof       <= 1'b0;
            vid.eol       <= 1'b0;
            vid.eof       <= 1'b0;
        end else begin
            de_d <= de;

            if (de) begin
                idle_cnt <= '0;
            end else if (idle_cnt != VBLANK_CYC) begin
                idle_cnt <= idle_cnt + 12'd1;
            end

            // x_cnt saturates at 2047; x_ovf marks a run longer than that.
            if (de) begin
                if (x_cnt == 11'h7FF) x_ovf <= 1'b1;
                else                  x_cnt <= x_cnt + 11'd1;
            end else if (fall) begin
                x_cnt <= '0;
                x_ovf <= 1'b0;
            end

            if (vb_evt) begin
                y_cnt <= '0;
            end else if (fall && y_cnt != 11'h7FF) begin
                y_cnt <= y_cnt + 11'd1;
            end

            if (state != MEASURE) begin
                h_have <= 1'b0;
            end else if (cap_w) begin
                h_have <= 1'b1;
                h_cap  <= x_cnt;
            end

            if (ld_meas) begin
                h_disp_meas <= h_cap;
                v_disp_meas <= y_cnt;
            end

            locked        <= (state_n == LOCKED);
            fmt_err       <= lock_err;
            vid.pix_valid <= pv;
            vid.pix_data  <= vid.lcd_rgb;
            vid.pix_x     <= x_cnt;
            vid.pix_y     <= y_cnt;
            vid.sof       <= pv & (x_cnt == 11'd0) & (y_cnt == 11'd0);
            vid.eol       <= eol_n;
            vid.eof       <= eol_n & (y_cnt == v_disp_meas - 11'd1);
        end
    end

endmodule

// File: tb/tb_rgb_de_rx.sv
// Directed bench for rgb_de_rx: small frame geometries with a short
// vblank threshold, error injection, mid-line reset, 2047-wide lines.
module tb_rgb_de_rx;

    localparam logic [11:0] VB_CYC = 12'd20;

    logic        lcd_pclk = 1'b0;
    logic        rst;
    logic        locked;
    logic        fmt_err;
    logic [10:0] h_disp_meas;
    logic [10:0] v_disp_meas;

    rgb_de_rx_if vid();

    rgb_de_rx #(.VBLANK_CYC(VB_CYC)) dut (
        .lcd_pclk    (lcd_pclk),
        .rst         (rst),
        .vid         (vid),
        .locked      (locked),
        .fmt_err     (fmt_err),
        .h_disp_meas (h_disp_meas),
        .v_disp_meas (v_disp_meas)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_pv, n_sof, n_eol, n_eof, n_err, n_bad, n_pv_after;
    int err_cyc;
    int cur_w, cur_h;
    int hb, vb;
    int row_start [0:15];
    int row_fall  [0:15];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pix_of(input int r, input int c);
        return 16'(r * 1031 + c * 37 + 32'h1234);
    endfunction

    task automatic clr();
        n_pv = 0; n_sof = 0; n_eol = 0; n_eof = 0;
        n_err = 0; n_bad = 0; n_pv_after = 0; err_cyc = -1;
    endtask

    task automatic tick(input logic de, input logic [15:0] rgb,
                        input int ex, input int ey);
        vid.lcd_de  = de;
        vid.lcd_rgb = rgb;
        @(posedge lcd_pclk);
        #1;
        cyc++;
        if (fmt_err === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
        if (vid.pix_data !== rgb) n_bad++;
        if (vid.pix_valid === 1'b1) begin
            n_pv++;
            if (n_err > 0) n_pv_after++;
            if (int'(vid.pix_x) != ex || int'(vid.pix_y) != ey) n_bad++;
        end
        if (vid.sof === 1'b1) begin
            n_sof++;
            if (vid.pix_x != 11'd0 || vid.pix_y != 11'd0) n_bad++;
        end
        if (vid.eol === 1'b1) begin
            n_eol++;
            if (int'(vid.pix_x) != cur_w - 1) n_bad++;
        end
        if (vid.eof === 1'b1) begin
            n_eof++;
            if (int'(vid.pix_x) != cur_w - 1 ||
                int'(vid.pix_y) != cur_h - 1) n_bad++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 16'h0000, 0, 0);
    endtask

    task automatic line(input int r, input int w);
        row_start[r % 16] = cyc + 1;
        for (int c = 0; c < w; c++) tick(1'b1, pix_of(r, c), c, r);
        row_fall[r % 16] = cyc + 1;
        idle(hb);
    endtask

    task automatic frame(input int w, input int h,
                         input int srow, input int sw);
        for (int r = 0; r < h; r++) line(r, (r == srow) ? sw : w);
        idle(vb);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"},
              {vid.pix_valid, vid.sof, vid.eol, vid.eof, locked, fmt_err}, 0);
        check({tag, "_data"}, {vid.pix_data, vid.pix_x, vid.pix_y}, 0);
        check({tag, "_meas"}, {h_disp_meas, v_disp_meas}, 0);
    endtask

    initial begin
        rst         = 1'b1;
        vid.lcd_de  = 1'b0;
        vid.lcd_rgb = 16'h0000;
        hb = 5; vb = 30; cur_w = 16; cur_h = 6;
        clr();

        do_reset();
        check_zero("reset");

        // Start mid-frame, then lock on the second vblank.
        clr();
        for (int r = 3; r < 6; r++) line(r, 16);
        idle(vb);
        check("lock_after_vb1", locked, 0);
        frame(16, 6, -1, 0);
        check("lock_after_vb2", locked, 1);
        check("h_meas", h_disp_meas, 16);
        check("v_meas", v_disp_meas, 6);
        check("pv_before_lock", n_pv, 0);

        clr();
        frame(16, 6, -1, 0);
        check("pv_frame", n_pv, 96);
        check("sof_frame", n_sof, 1);
        check("eol_frame", n_eol, 6);
        check("eof_frame", n_eof, 1);
        check("bad_frame", n_bad, 0);
        check("err_frame", n_err, 0);

        // Row 2 short by one pixel.
        clr();
        frame(16, 6, 2, 15);
        check("short_err_n", n_err, 1);
        check("short_err_cyc", err_cyc, row_fall[2]);
        check("short_pv", n_pv, 47);
        check("short_pv_after", n_pv_after, 0);
        check("short_unlock", locked, 0);
        frame(16, 6, -1, 0);
        check("short_relock", locked, 1);

        // Row 1 one pixel too long.
        clr();
        frame(16, 6, 1, 17);
        check("ovr_err_n", n_err, 1);
        check("ovr_err_cyc", err_cyc, row_start[1] + 16);
        check("ovr_pv", n_pv, 32);
        check("ovr_unlock", locked, 0);
        frame(16, 6, -1, 0);
        check("ovr_relock", locked, 1);

        // One extra line.
        clr();
        frame(16, 7, -1, 0);
        check("extra_err_n", n_err, 1);
        check("extra_err_cyc", err_cyc, row_start[6]);
        check("extra_pv", n_pv, 96);
        check("extra_pv_after", n_pv_after, 0);
        frame(16, 6, -1, 0);
        check("extra_relock", locked, 1);

        // One line missing: the same vblank starts the re-measure.
        clr();
        frame(16, 5, -1, 0);
        check("sfrm_err_n", n_err, 1);
        check("sfrm_err_cyc", err_cyc, row_fall[4] + int'(VB_CYC) - 1);
        check("sfrm_pv", n_pv, 80);
        check("sfrm_unlock", locked, 0);
        clr();
        frame(16, 6, -1, 0);
        check("sfrm_relock", locked, 1);
        check("sfrm_relock_err", n_err, 0);

        // One-clock reset in the middle of row 2.
        clr();
        line(0, 16);
        line(1, 16);
        for (int c = 0; c < 5; c++) tick(1'b1, pix_of(2, c), c, 2);
        rst = 1'b1;
        tick(1'b1, 16'h0000, 5, 2);
        rst = 1'b0;
        check_zero("midrst");
        for (int c = 6; c < 16; c++) tick(1'b1, pix_of(2, c), c, 2);
        idle(hb);
        for (int r = 3; r < 6; r++) line(r, 16);
        idle(vb);
        check("midrst_vb1", locked, 0);
        frame(16, 6, -1, 0);
        check("midrst_relock", locked, 1);
        check("midrst_err", n_err, 0);
        check("midrst_h", h_disp_meas, 16);

        // Second geometry with a wider hblank.
        hb = 8; cur_w = 24; cur_h = 4;
        do_reset();
        idle(vb);
        frame(24, 4, -1, 0);
        check("g2_lock", locked, 1);
        check("g2_meas", {h_disp_meas, v_disp_meas}, {11'd24, 11'd4});
        clr();
        frame(24, 4, -1, 0);
        check("g2_pv", n_pv, 96);
        check("g2_sof", n_sof, 1);
        check("g2_eol", n_eol, 4);
        check("g2_eof", n_eof, 1);
        check("g2_bad", n_bad, 0);

        // Maximum legal width; a 2048th sample overruns.
        hb = 5; cur_w = 2047; cur_h = 2;
        do_reset();
        idle(vb);
        frame(2047, 2, -1, 0);
        check("w2047_lock", locked, 1);
        check("w2047_h", h_disp_meas, 2047);
        clr();
        frame(2047, 2, -1, 0);
        check("w2047_pv", n_pv, 4094);
        check("w2047_eol", n_eol, 2);
        check("w2047_eof", n_eof, 1);
        check("w2047_bad", n_bad, 0);
        clr();
        frame(2047, 2, 0, 2048);
        check("w2048_err_n", n_err, 1);
        check("w2048_err_cyc", err_cyc, row_start[0] + 2047);
        check("w2048_pv", n_pv, 2047);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule
